// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU MEM stage and the debug loader.
// Arbitration mode is selected by DMEM_ARB_RR_EN (see dmem_arb_pick).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    // Counter preload so that BUSY lasts exactly lat cycles.
    function automatic logic [CNT_W-1:0] cnt_init(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection between CPU and debug requests.
// DMEM_ARB_RR_EN defined: contention goes to the side not served last; undefined: CPU always wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  logic   last_cpu,
    output logic   gnt_valid,
    output owner_e gnt_owner
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        gnt_valid = cpu_req | dbg_req;
        gnt_owner = OWN_CPU;
        if (cpu_req && dbg_req) begin
            gnt_owner = last_cpu ? OWN_DBG : OWN_CPU;
        end else if (dbg_req) begin
            gnt_owner = OWN_DBG;
        end
    end
`else
    logic unused_last_cpu;
    assign unused_last_cpu = last_cpu;

    always_comb begin
        gnt_valid = cpu_req | dbg_req;
        gnt_owner = OWN_CPU;
        if (dbg_req && !cpu_req) begin
            gnt_owner = OWN_DBG;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU MEM stage vs. debug loader, fixed-latency memory access.
// Grant policy selected by DMEM_ARB_RR_EN (round-robin when defined, CPU priority otherwise).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int LAT = 1,
    parameter int AW  = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [31:0]   cpu_wdata_i,
    output logic [31:0]   cpu_rdata_o,
    output logic          cpu_stall_o,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [31:0]   dbg_wdata_i,
    output logic          dbg_ack_o,
    output logic [31:0]   dbg_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          mem_MemRead_o,
    output logic          mem_MemWrite_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam logic [CNT_W-1:0] CNT_INIT = cnt_init(LAT);

    arb_state_e       state_reg, state_next;
    owner_e           owner_reg, owner_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [AW-1:0]    addr_reg,  addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             we_reg,    we_next;
    // Cleared once the owner drops its request; a dead access still runs but reports nothing.
    logic             alive_reg, alive_next;

    logic   gnt_valid;
    owner_e gnt_owner;
    logic   owner_req;
    logic   cap_en;

    dmem_arb_pick u_pick (
        .cpu_req   (cpu_req_i),
        .dbg_req   (dbg_req_i),
        .last_cpu  (owner_reg == OWN_CPU),
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner)
    );

    assign owner_req = (owner_reg == OWN_DBG) ? dbg_req_i : cpu_req_i;
    assign cap_en    = (state_reg == ST_BUSY) && (cnt_reg == '0) && alive_reg
                       && owner_req && !we_reg;

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        we_next    = we_reg;
        alive_next = alive_reg;
        case (state_reg)
            ST_IDLE: begin
                if (gnt_valid) begin
                    owner_next = gnt_owner;
                    cnt_next   = CNT_INIT;
                    alive_next = 1'b1;
                    state_next = ST_BUSY;
                    if (gnt_owner == OWN_DBG) begin
                        addr_next  = dbg_addr_i;
                        wdata_next = dbg_wdata_i;
                        we_next    = dbg_we_i;
                    end else begin
                        addr_next  = cpu_addr_i;
                        wdata_next = cpu_wdata_i;
                        we_next    = cpu_we_i;
                    end
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    alive_next = 1'b0;
                end
                if (cnt_reg == '0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_CPU;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            alive_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            we_reg    <= we_next;
            alive_reg <= alive_next;
        end
    end

    // Per-owner read-data holding registers; index follows the owner_e encoding.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            logic [31:0] rdata_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rdata_reg <= '0;
                end else if (cap_en && (int'(owner_reg) == gi)) begin
                    rdata_reg <= mem_rdata_i;
                end
            end
        end
    endgenerate

    assign cpu_rdata_o    = g_rdata[0].rdata_reg;
    assign dbg_rdata_o    = g_rdata[1].rdata_reg;
    assign mem_addr_o     = addr_reg;
    assign mem_wdata_o    = wdata_reg;
    assign mem_MemWrite_o = (state_reg == ST_BUSY) && we_reg;
    assign mem_MemRead_o  = (state_reg == ST_BUSY) && !we_reg;
    assign dbg_ack_o      = (state_reg == ST_RESP) && (owner_reg == OWN_DBG)
                            && alive_reg && dbg_req_i;
    assign cpu_stall_o    = cpu_req_i && !((state_reg == ST_RESP) && (owner_reg == OWN_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 at LAT=1, instance 1 at LAT=3, each with its own behavioural memory.
// Contention expectations follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req [N];
    logic        cpu_we [N];
    logic [31:0] cpu_addr [N];
    logic [31:0] cpu_wdata [N];
    logic [31:0] cpu_rdata [N];
    logic        cpu_stall [N];
    logic        dbg_req [N];
    logic        dbg_we [N];
    logic [31:0] dbg_addr [N];
    logic [31:0] dbg_wdata [N];
    logic        dbg_ack [N];
    logic [31:0] dbg_rdata [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_wd [N];
    logic [31:0] m_rd [N];
    logic        m_rd_en [N];
    logic        m_we [N];

    logic [31:0] tbmem [N][16];
    logic        pl_en;
    int          pl_inst;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            dmem_arbiter #(.LAT(gi == 0 ? 1 : 3), .AW(AW)) dut (
                .clk_i          (clk),
                .rst_i          (rst),
                .cpu_req_i      (cpu_req[gi]),
                .cpu_we_i       (cpu_we[gi]),
                .cpu_addr_i     (cpu_addr[gi]),
                .cpu_wdata_i    (cpu_wdata[gi]),
                .cpu_rdata_o    (cpu_rdata[gi]),
                .cpu_stall_o    (cpu_stall[gi]),
                .dbg_req_i      (dbg_req[gi]),
                .dbg_we_i       (dbg_we[gi]),
                .dbg_addr_i     (dbg_addr[gi]),
                .dbg_wdata_i    (dbg_wdata[gi]),
                .dbg_ack_o      (dbg_ack[gi]),
                .dbg_rdata_o    (dbg_rdata[gi]),
                .mem_addr_o     (m_addr[gi]),
                .mem_wdata_o    (m_wd[gi]),
                .mem_MemRead_o  (m_rd_en[gi]),
                .mem_MemWrite_o (m_we[gi]),
                .mem_rdata_i    (m_rd[gi])
            );
            assign m_rd[gi] = tbmem[gi][m_addr[gi][5:2]];
        end
    endgenerate

    always @(posedge clk) begin
        if (pl_en) tbmem[pl_inst][pl_idx] <= pl_data;
        for (int i = 0; i < N; i++) begin
            if (m_we[i]) tbmem[i][m_addr[i][5:2]] <= m_wd[i];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          rd_cyc;
        int          wr_cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          inst;
        logic        is_dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [13];

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic do_txn(input int inst, input logic is_dbg, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata);
        exp_t e;
        int c = 0, rc = 0, wc = 0, both = 0;
        logic done = 1'b0;
        logic [31:0] got;
        e.rdata  = exp_rdata;
        e.lat    = lat_of(inst) + 2;
        e.rd_cyc = we ? 0 : lat_of(inst);
        e.wr_cyc = we ? lat_of(inst) : 0;
        sb.push_back(e);
        if (is_dbg) begin
            dbg_req[inst] = 1'b1; dbg_we[inst] = we; dbg_addr[inst] = addr; dbg_wdata[inst] = wdata;
        end else begin
            cpu_req[inst] = 1'b1; cpu_we[inst] = we; cpu_addr[inst] = addr; cpu_wdata[inst] = wdata;
        end
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            rc   += int'(m_rd_en[inst]);
            wc   += int'(m_we[inst]);
            both += int'(m_rd_en[inst] && m_we[inst]);
            done  = is_dbg ? dbg_ack[inst] : !cpu_stall[inst];
        end
        got = is_dbg ? dbg_rdata[inst] : cpu_rdata[inst];
        e = sb.pop_front();
        check("txn completes", 32'(done), 32'd1);
        check("txn latency", 32'(c), 32'(e.lat));
        check("txn read strobe cycles", 32'(rc), 32'(e.rd_cyc));
        check("txn write strobe cycles", 32'(wc), 32'(e.wr_cyc));
        check("txn strobes exclusive", 32'(both), 32'd0);
        check("txn rdata", got, e.rdata);
        $display("txn inst%0d %s %s addr=%h lat=%0d rdata=%h", inst, is_dbg ? "dbg" : "cpu",
                 we ? "wr" : "rd", addr, c, got);
        @(posedge clk); #1;
        if (is_dbg) dbg_req[inst] = 1'b0;
        else        cpu_req[inst] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            cpu_req[i] = 1'b0; dbg_req[i] = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ord_q[$];
        int   cpu_n, cyc, acks, rds;
        logic ev_cpu, ev_dbg, exp_dbg;

        rst = 1'b1;
        pl_en = 1'b0; pl_inst = 0; pl_idx = '0; pl_data = '0;
        for (int i = 0; i < N; i++) begin
            cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            dbg_req[i] = 1'b0; dbg_we[i] = 1'b0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 16; k++) begin
                pl_en   = 1'b1;
                pl_inst = i;
                pl_idx  = 4'(k);
                pl_data = (i == 0) ? ((k == 0) ? 32'd5 : 32'hA000_0000 + 32'(k))
                                   : 32'hC0DE_0000 + 32'(k);
                @(posedge clk); #1;
            end
        end
        pl_en = 1'b0;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("reset stall", 32'(cpu_stall[i]), 32'd0);
            check("reset dbg_ack", 32'(dbg_ack[i]), 32'd0);
            check("reset MemRead", 32'(m_rd_en[i]), 32'd0);
            check("reset MemWrite", 32'(m_we[i]), 32'd0);
            check("reset cpu_rdata", cpu_rdata[i], 32'd0);
            check("reset dbg_rdata", dbg_rdata[i], 32'd0);
        end
        cpu_req[1] = 1'b1;
        #1;
        check("stall follows req in reset", 32'(cpu_stall[1]), 32'd1);
        cpu_req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        vecs[0]  = '{0, 1'b0, 1'b0, 32'h00, 32'h0,         32'd5};
        vecs[1]  = '{0, 1'b1, 1'b1, 32'h0C, 32'h77,        32'h0};
        vecs[2]  = '{0, 1'b1, 1'b0, 32'h0C, 32'h0,         32'h77};
        vecs[3]  = '{0, 1'b0, 1'b0, 32'h0C, 32'h0,         32'h77};
        vecs[4]  = '{1, 1'b0, 1'b0, 32'h08, 32'h0,         32'hC0DE_0002};
        vecs[5]  = '{1, 1'b1, 1'b1, 32'h04, 32'hA5,        32'h0};
        vecs[6]  = '{1, 1'b1, 1'b0, 32'h04, 32'h0,         32'hA5};
        vecs[7]  = '{1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'hC0DE_0002};
        vecs[8]  = '{1, 1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        vecs[9]  = '{1, 1'b1, 1'b0, 32'h3C, 32'h0,         32'hC0DE_000F};
        vecs[10] = '{1, 1'b0, 1'b0, 32'h04, 32'h0,         32'hA5};
        vecs[11] = '{1, 1'b1, 1'b1, 32'h08, 32'h1234_5678, 32'hC0DE_000F};
        vecs[12] = '{1, 1'b0, 1'b0, 32'h08, 32'h0,         32'h1234_5678};
        for (int v = 0; v < 13; v++) begin
            do_txn(vecs[v].inst, vecs[v].is_dbg, vecs[v].we, vecs[v].addr,
                   vecs[v].wdata, vecs[v].exp_rdata);
        end
        check("memory word 0x04", tbmem[1][1], 32'hA5);
        check("memory word 0x08", tbmem[1][2], 32'h1234_5678);

        // Contention: both request reads; CPU drops out after its third completion.
        do_reset();
`ifdef DMEM_ARB_RR_EN
        ord_q.push_back(1'b1); ord_q.push_back(1'b0); ord_q.push_back(1'b1);
        ord_q.push_back(1'b0); ord_q.push_back(1'b1); ord_q.push_back(1'b0);
        ord_q.push_back(1'b1);
`else
        ord_q.push_back(1'b0); ord_q.push_back(1'b0); ord_q.push_back(1'b0);
        ord_q.push_back(1'b1);
`endif
        cpu_we[1] = 1'b0; cpu_addr[1] = 32'h14; cpu_req[1] = 1'b1;
        dbg_we[1] = 1'b0; dbg_addr[1] = 32'h18; dbg_req[1] = 1'b1;
        cpu_n = 0;
        cyc   = 0;
        while (ord_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            ev_cpu = cpu_req[1] && !cpu_stall[1];
            ev_dbg = dbg_ack[1];
            if (ev_cpu || ev_dbg) begin
                exp_dbg = ord_q.pop_front();
                check("contention grant order", 32'(ev_dbg), 32'(exp_dbg));
                if (ev_dbg) check("contention dbg rdata", dbg_rdata[1], 32'hC0DE_0006);
                else        check("contention cpu rdata", cpu_rdata[1], 32'hC0DE_0005);
                if (ev_cpu) cpu_n++;
                $display("contention event %s at cycle %0d", ev_dbg ? "dbg" : "cpu", cyc);
            end
            @(posedge clk); #1;
            if (cpu_n == 3) cpu_req[1] = 1'b0;
        end
        check("contention all grants seen", 32'(ord_q.size()), 32'd0);
        cpu_req[1] = 1'b0;
        dbg_req[1] = 1'b0;
        @(posedge clk); #1;

        // Reset while a debug write is in BUSY.
        dbg_we[1] = 1'b1; dbg_addr[1] = 32'h20; dbg_wdata[1] = 32'h5A; dbg_req[1] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort: write in progress", 32'(m_we[1]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        dbg_req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort: MemWrite low", 32'(m_we[1]), 32'd0);
        check("abort: MemRead low", 32'(m_rd_en[1]), 32'd0);
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            acks += int'(dbg_ack[1]);
            @(negedge clk);
        end
        check("abort: no ack", 32'(acks), 32'd0);
        $display("txn inst1 dbg wr addr=00000020 aborted by reset acks=%0d", acks);
        @(posedge clk); #1;

        // Debug drops its request mid-access.
        do_txn(1, 1'b1, 1'b0, 32'h3C, 32'h0, 32'hC0DE_000F);
        dbg_we[1] = 1'b0; dbg_addr[1] = 32'h24; dbg_req[1] = 1'b1;
        acks = 0;
        rds  = 0;
        @(negedge clk);
        rds += int'(m_rd_en[1]);
        @(posedge clk); #1;
        @(negedge clk);
        rds += int'(m_rd_en[1]);
        @(posedge clk); #1;
        dbg_req[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rds  += int'(m_rd_en[1]);
            acks += int'(dbg_ack[1]);
        end
        check("drop: access completes", 32'(rds), 32'd3);
        check("drop: no ack", 32'(acks), 32'd0);
        check("drop: dbg_rdata held", dbg_rdata[1], 32'hC0DE_000F);
        $display("txn inst1 dbg rd addr=00000024 dropped acks=%0d rdata=%h", acks, dbg_rdata[1]);
        @(posedge clk); #1;
        do_txn(1, 1'b1, 1'b0, 32'h24, 32'h0, 32'hC0DE_0009);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LAT, default 1, memory access latency in cycles; legal range 1..15.
REQ-002 Parameter AW, default 32, address width.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 cpu_req_i  in  1  CPU MEM-stage access request, held until served.
REQ-006 cpu_we_i  in  1  CPU write (1) / read (0).
REQ-007 cpu_addr_i  in  AW  CPU byte address.
REQ-008 cpu_wdata_i  in  32  CPU write data.
REQ-009 cpu_rdata_o  out  32  CPU read data, valid while cpu_stall_o=0 after a CPU read.
REQ-010 cpu_stall_o  out  1  pipeline stall to hazard logic.
REQ-011 dbg_req_i / dbg_we_i / dbg_addr_i[AW] / dbg_wdata_i[32]  in  debug loader port, same meanings as CPU port.
REQ-012 dbg_ack_o  out  1  one-cycle completion pulse; dbg_rdata_o  out  32  read data valid with ack.
REQ-013 mem_addr_o[AW], mem_wdata_o[32], mem_MemRead_o, mem_MemWrite_o  out  Data_Memory drive; mem_rdata_i[32]  in.

Function
REQ-014 FSM states IDLE, BUSY, RESP; owner register CPU/DBG; down-counter cnt[3:0].
REQ-015 IDLE with any request: grant per REQ-022, latch addr/we/wdata, cnt<=LAT-1, go BUSY next edge.
REQ-016 BUSY: mem_addr_o/mem_wdata_o from latched values; MemWrite_o=we, MemRead_o=~we; cnt decrements each cycle.
REQ-017 BUSY with cnt==0: latch mem_rdata_i into owner's rdata register, go RESP.
REQ-018 RESP: exactly one cycle; strobes low; dbg_ack_o=1 if owner DBG; go IDLE.
REQ-019 Access latency request-to-response = LAT+2 cycles; back-to-back requests add no idle cycle beyond RESP->IDLE.
REQ-020 cpu_stall_o = cpu_req_i AND NOT (state==RESP AND owner==CPU); combinational; 0 when cpu_req_i=0.
REQ-021 Requester deasserting mid-access: access completes, response dropped (no ack, rdata not updated); latched inputs ignore later changes.
REQ-022 Simultaneous requests in IDLE resolved per REQ-026; loser waits, stalled/unacked.
REQ-023 Strobes never both high; outside BUSY both low; mem_addr_o/mem_wdata_o hold last latched value.
REQ-024 cpu_rdata_o/dbg_rdata_o hold value until next completed read by that owner.

Reset
REQ-025 rst_i=1 at edge: state IDLE, cnt 0, owner CPU, last-served CPU, rdata regs 0, strobes 0, dbg_ack_o 0; applies mid-access, in-flight access aborted without ack; cpu_stall_o follows REQ-020.

Configuration
REQ-026 DMEM_ARB_RR_EN defined: round-robin, contention granted to requester not last served; undefined: fixed priority, CPU always wins.

Structure
REQ-027 Shared package dmem_arb_pkg: FSM state enum, owner encoding, LAT range constants.
REQ-028 One sub-module dmem_arb_pick: combinational grant selection from req pair and last-served flag.

Verification
REQ-029 LAT=1, CPU read 0x00 with mem=5 -> stall high 2 cycles, cycle 3 stall low, cpu_rdata_o=5.
REQ-030 LAT=3, DBG write 0x04=0xA5 -> MemWrite_o high 3 cycles, dbg_ack_o pulse at cycle 5, memory[0x04]=0xA5.
REQ-031 Simultaneous CPU+DBG reads, macro undefined, repeated -> CPU served every time, DBG never acked while CPU holds req.
REQ-032 Same with DMEM_ARB_RR_EN -> grants alternate DBG, CPU, DBG (last-served CPU after reset).
REQ-033 rst_i asserted during BUSY of DBG write -> next cycle IDLE, strobes 0, no dbg_ack_o.
REQ-034 DBG drops req in BUSY -> access completes, no ack, dbg_rdata_o unchanged.
